// File: rtl/lp_rle_pkg.sv
// Shared types for the zero-run-length packer: token layout, row FSM states, run ceiling helper.
package lp_rle_pkg;

    localparam int unsigned TOK_DW  = 8;
    localparam int unsigned TOK_RLW = 4;

    typedef struct packed {
        logic [TOK_RLW-1:0] run;
        logic [TOK_DW-1:0]  val;
        logic               last;
    } rle_tok_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ROW  = 1'b1
    } rle_state_e;

    function automatic int unsigned run_max(input int unsigned rlw);
        return (32'd1 << rlw) - 32'd1;
    endfunction

endpackage

// File: rtl/pbpix_tok_slot.sv
// One-entry rdy/ack token register: loads when free, holds rdy and contents stable until acked.
// A drain and a load on the same edge replace the token without dropping rdy.
module pbpix_tok_slot
    import lp_rle_pkg::*;
#(
    parameter type tok_t = rle_tok_t
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic load_i,
    input  tok_t tok_i,
    input  logic ack_i,
    output logic rdy_o,
    output tok_t tok_o,
    output logic free_o
);

    logic rdy_q;
    tok_t tok_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdy_q <= 1'b0;
            tok_q <= '0;
        end else if (load_i) begin
            rdy_q <= 1'b1;
            tok_q <= tok_i;
        end else if (rdy_q && ack_i) begin
            rdy_q <= 1'b0;
        end
    end

    assign rdy_o  = rdy_q;
    assign tok_o  = tok_q;
    assign free_o = !rdy_q || ack_i;

endmodule

// File: rtl/pbpix_rle_packer.sv
// Row-wise run-length packer of zero-flagged pixels into {run, val, last} tokens, 1-cycle latency.
// Optional statistics counters are enabled by defining RLE_STAT_EN.
module pbpix_rle_packer
    import lp_rle_pkg::*;
#(
    parameter int DW   = 8,
    parameter int RLW  = 4,
    parameter int ROWW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [ROWW-1:0] i_row_len,
    input  logic            pix_rdy,
    output logic            pix_ack,
    input  logic            pix_zero,
    input  logic [DW-1:0]   pix_data,
    output logic            rle_rdy,
    input  logic            rle_ack,
    output logic [RLW-1:0]  rle_run,
    output logic [DW-1:0]   rle_val,
    output logic            rle_last
`ifdef RLE_STAT_EN
    ,
    output logic [31:0]     stat_zero_cnt,
    output logic [31:0]     stat_tok_cnt
`endif
);

    localparam logic [RLW-1:0] RUN_MAX = RLW'(run_max(RLW));

    typedef struct packed {
        logic [RLW-1:0] run;
        logic [DW-1:0]  val;
        logic           last;
    } tok_t;

    rle_state_e      state_q;
    logic [ROWW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_len_q;
    logic [ROWW-1:0] row_len_cur;
    logic [ROWW-1:0] last_col;
    logic [RLW-1:0]  run_q, run_d;
    logic            slot_free;
    logic            acc;
    logic            is_last;
    logic            absorb;
    logic            load;
    tok_t            tok_d;
    tok_t            tok_q;

    assign pix_ack = slot_free;
    assign acc     = pix_rdy && slot_free;

    // Row length is taken live on the first pixel of a row, then frozen.
    assign row_len_cur = (state_q == S_IDLE) ? i_row_len : row_len_q;
    assign last_col    = row_len_cur - ROWW'(1);
    assign is_last     = (col_q == last_col);

    assign absorb = acc && pix_zero && !is_last && (run_q != RUN_MAX);
    assign load   = acc && !absorb;

    assign col_d = is_last ? '0 : col_q + ROWW'(1);
    assign run_d = absorb ? run_q + RLW'(1) : '0;

    always_comb begin
        tok_d      = '0;
        tok_d.run  = run_q;
        tok_d.val  = pix_zero ? '0 : pix_data;
        tok_d.last = is_last;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            run_q     <= '0;
            row_len_q <= '0;
        end else if (acc) begin
            col_q <= col_d;
            run_q <= run_d;
            case (state_q)
                S_IDLE: begin
                    row_len_q <= i_row_len;
                    state_q   <= is_last ? S_IDLE : S_ROW;
                end
                S_ROW: begin
                    state_q <= is_last ? S_IDLE : S_ROW;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    pbpix_tok_slot #(
        .tok_t (tok_t)
    ) u_slot (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .load_i (load),
        .tok_i  (tok_d),
        .ack_i  (rle_ack),
        .rdy_o  (rle_rdy),
        .tok_o  (tok_q),
        .free_o (slot_free)
    );

    assign rle_run  = tok_q.run;
    assign rle_val  = tok_q.val;
    assign rle_last = tok_q.last;

`ifdef RLE_STAT_EN
    logic [31:0] zero_cnt_q;
    logic [31:0] tok_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            zero_cnt_q <= '0;
            tok_cnt_q  <= '0;
        end else begin
            if (absorb && (zero_cnt_q != '1)) begin
                zero_cnt_q <= zero_cnt_q + 32'd1;
            end
            if (rle_rdy && rle_ack && (tok_cnt_q != '1)) begin
                tok_cnt_q <= tok_cnt_q + 32'd1;
            end
        end
    end

    assign stat_zero_cnt = zero_cnt_q;
    assign stat_tok_cnt  = tok_cnt_q;
`endif

endmodule
